alt_vipitc130_is2vid_sof_lock: RTL and testbench
================================================

# alt_vipitc130_IS2Vid_sof_lock

Start-of-frame lock detector for one video timing source, either CVI or CVO. It sits directly upstream of the genlock sync comparator and supplies that block's `sof_*` and `sof_*_locked` inputs. It edge-detects the incoming SOF level and measures the frame period in `clk` cycles. It asserts lock after a run of consistent periods and drops lock on repeated mismatches, timeout or disable. One instance is used per source.

## Interface
Parameters:
- `PERIOD_WIDTH`, 24: width of the period counter; an all-ones count means timeout.
- `LOCK_FRAMES`, 3: consecutive matching periods, after the reference period, required to lock (1..15).
- `UNLOCK_FRAMES`, 2: consecutive mismatching periods while locked that drop lock (1..15).
- `TOLERANCE`, 0: maximum absolute difference (cycles) between a period and the reference that still counts as a match.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  high = detector active; low = synchronous clear.
- `sof`  in  1  SOF level, already synchronous to `clk`; a rising edge marks start of frame.
- `sof_pulse`  out  1  one-cycle registered pulse per detected rising edge.
- `sof_locked`  out  1  period lock achieved.
- `period`  out  PERIOD_WIDTH  last measured period, in cycles between edges.
- `period_valid`  out  1  `period` holds a measurement taken since the last clear or timeout.

## Operation
- Edge detect:
  - `sof_reg` is a registered copy of `sof`.
  - Edge is `sof & ~sof_reg`.
  - `sof_reg` resets to 0, so `sof` high at reset release counts as an edge.
  - `sof_reg` tracks `sof` even while `enable` is low.
- Period counter `cnt`:
  - On an edge, `cnt` is loaded with 1.
  - Otherwise `cnt` increments and saturates at all-ones.
  - Edges N cycles apart therefore capture `cnt` == N.
- Match test: |N − ref| <= `TOLERANCE`, computed unsigned with one extra bit; no wrap.
- States:
  - **IDLE**
    - Edge → MEASURE.
  - **MEASURE** (one edge seen)
    - Edge → `ref` <= N, `match_cnt` <= 0, go ACQUIRE.
  - **ACQUIRE**
    - Match edge: `match_cnt`++.
    - When `match_cnt` reaches `LOCK_FRAMES` → LOCKED, `miss_cnt` <= 0.
    - Mismatch edge: `ref` <= N, `match_cnt` <= 0, stay in ACQUIRE.
  - **LOCKED**
    - Match edge: `miss_cnt` <= 0; `ref` is unchanged.
    - Mismatch edge: `miss_cnt`++.
    - When `miss_cnt` reaches `UNLOCK_FRAMES` → ACQUIRE, `ref` <= N, `match_cnt` <= 0.
- Timeout, in MEASURE, ACQUIRE or LOCKED: when `cnt` is all-ones with no edge → IDLE, `period_valid` <= 0.
- Edge in the same cycle that `cnt` is all-ones: the period is discarded and the FSM goes to MEASURE (this edge becomes the new first edge).
- `enable` low:
  - FSM → IDLE; `cnt`, `ref`, `match_cnt` and `miss_cnt` are cleared.
  - `sof_locked`, `period_valid` and `sof_pulse` are forced to 0.
  - `enable` low has priority over every other condition.
- `sof_locked` = (state == LOCKED), registered.

## Timing
- Reset values: `sof_pulse` 0, `sof_locked` 0, `period` 0, `period_valid` 0, state IDLE, all counters 0.
- `sof_pulse`: high in the cycle after the edge cycle (latency 1), never two consecutive cycles.
- `period` and `period_valid` update on the same cycle as `sof_pulse` for every edge from MEASURE onward.
- `sof_locked` changes on the same cycle as the `sof_pulse` of the edge that causes the transition.
- Timeout drop happens one cycle after `cnt` reaches all-ones, i.e. 2^`PERIOD_WIDTH`−1 cycles after the last `sof_pulse`.
- `rst` mid-operation: all outputs drop to reset values immediately (asynchronously); lock must be fully re-acquired.

## Test plan
- Defaults; `sof` rising every 100 cycles:
  - Edges e0–e3: `sof_locked` stays 0.
  - `sof_locked` rises together with the `sof_pulse` of e4.
  - `period` = 100 and `period_valid` = 1 from the `sof_pulse` of e1 onward.
- Locked at 100:
  - One 101-cycle period → lock held.
  - Then 100 → `miss_cnt` cleared.
  - Then 101, 101 → lock drops on the second 101.
  - Three further 101-cycle periods → relock (`ref` = 101).
- `TOLERANCE`=2; periods 100, 102, 98, 101 → locked on the last one. A later period of 97 counts as a mismatch.
- `PERIOD_WIDTH`=8, locked at 100, `sof` held low → `sof_locked` and `period_valid` fall exactly 255 cycles after the last `sof_pulse`.
- Locked; `enable` low for 1 cycle → `sof_locked` is 0 the next cycle. After `enable` returns high, 5 further edges at 100 are needed to relock.
- `sof` held high across `rst` release → `sof_pulse` fires 1 cycle after release. Assert `rst` mid-lock → all outputs are 0 immediately.

Source files
------------

// File: rtl/alt_vipitc130_is2vid_sof_lock.sv
// SOF lock detector: edge-detects one video SOF level, measures the frame
// period and reports lock once the period has been stable for enough frames.
module alt_vipitc130_is2vid_sof_lock #(
  parameter int PERIOD_WIDTH  = 24,
  parameter int LOCK_FRAMES   = 3,
  parameter int UNLOCK_FRAMES = 2,
  parameter int TOLERANCE     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sof,
  output logic                    sof_pulse,
  output logic                    sof_locked,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_ACQUIRE,
    S_LOCKED
  } state_t;

  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE =
    PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH:0] TOL =
    (PERIOD_WIDTH+1)'(TOLERANCE);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_FRAMES);

  state_t                  state;
  logic                    sof_reg;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] ref_period;
  logic [3:0]              match_cnt;
  logic [3:0]              miss_cnt;

  logic                    sof_edge;
  logic                    cnt_full;
  logic                    timeout;
  logic [PERIOD_WIDTH:0]   cnt_x;
  logic [PERIOD_WIDTH:0]   ref_x;
  logic [PERIOD_WIDTH:0]   diff;
  logic                    is_match;

  assign sof_edge = sof & ~sof_reg;
  assign cnt_full = (cnt == CNT_MAX);
  // A saturated count means the period is unknown, even if an edge
  // arrives in the same cycle; that edge restarts measurement.
  assign timeout  = cnt_full && (state != S_IDLE);

  assign cnt_x    = {1'b0, cnt};
  assign ref_x    = {1'b0, ref_period};
  assign diff     = (cnt_x >= ref_x) ? (cnt_x - ref_x)
                                     : (ref_x - cnt_x);
  assign is_match = (diff <= TOL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      sof_reg      <= 1'b0;
      cnt          <= '0;
      ref_period   <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      sof_pulse    <= 1'b0;
      sof_locked   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      sof_reg <= sof;
      if (!enable) begin
        state        <= S_IDLE;
        cnt          <= '0;
        ref_period   <= '0;
        match_cnt    <= '0;
        miss_cnt     <= '0;
        sof_pulse    <= 1'b0;
        sof_locked   <= 1'b0;
        period_valid <= 1'b0;
      end else begin
        sof_pulse <= sof_edge;

        if (sof_edge) begin
          cnt <= CNT_ONE;
        end else if (!cnt_full) begin
          cnt <= cnt + CNT_ONE;
        end

        if (timeout) begin
          state        <= sof_edge ? S_MEASURE : S_IDLE;
          sof_locked   <= 1'b0;
          period_valid <= 1'b0;
          match_cnt    <= '0;
          miss_cnt     <= '0;
        end else if (sof_edge) begin
          if (state != S_IDLE) begin
            period       <= cnt;
            period_valid <= 1'b1;
          end
          unique case (state)
            S_IDLE: begin
              state <= S_MEASURE;
            end
            S_MEASURE: begin
              ref_period <= cnt;
              match_cnt  <= '0;
              state      <= S_ACQUIRE;
            end
            S_ACQUIRE: begin
              if (is_match) begin
                if (match_cnt + 4'd1 == LOCK_N) begin
                  state      <= S_LOCKED;
                  sof_locked <= 1'b1;
                  miss_cnt   <= '0;
                  match_cnt  <= '0;
                end else begin
                  match_cnt <= match_cnt + 4'd1;
                end
              end else begin
                ref_period <= cnt;
                match_cnt  <= '0;
              end
            end
            S_LOCKED: begin
              if (is_match) begin
                miss_cnt <= '0;
              end else if (miss_cnt + 4'd1 == UNLOCK_N) begin
                state      <= S_ACQUIRE;
                sof_locked <= 1'b0;
                ref_period <= cnt;
                match_cnt  <= '0;
                miss_cnt   <= '0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_alt_vipitc130_is2vid_sof_lock.sv
// Directed bench for the SOF lock detector: lock, tracking, tolerance,
// timeout, enable clear and reset behaviour across three configurations.
module tb_alt_vipitc130_is2vid_sof_lock;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sof_in [3];
  logic en_in  [3];

  logic        pul0, lck0, val0;
  logic [23:0] per0;
  logic        pul1, lck1, val1;
  logic [23:0] per1;
  logic        pul2, lck2, val2;
  logic [7:0]  per2;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alt_vipitc130_is2vid_sof_lock dut0 (
    .clk(clk), .rst(rst), .enable(en_in[0]), .sof(sof_in[0]),
    .sof_pulse(pul0), .sof_locked(lck0),
    .period(per0), .period_valid(val0)
  );

  alt_vipitc130_is2vid_sof_lock #(.TOLERANCE(2)) dut1 (
    .clk(clk), .rst(rst), .enable(en_in[1]), .sof(sof_in[1]),
    .sof_pulse(pul1), .sof_locked(lck1),
    .period(per1), .period_valid(val1)
  );

  alt_vipitc130_is2vid_sof_lock #(.PERIOD_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .enable(en_in[2]), .sof(sof_in[2]),
    .sof_pulse(pul2), .sof_locked(lck2),
    .period(per2), .period_valid(val2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // After return, the outputs reflect the pulse of this edge.
  task automatic fire(input int d);
    sof_in[d] = 1'b1;
    tick();
    sof_in[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      sof_in[i] = 1'b0;
      en_in[i]  = 1'b1;
    end
    rst = 1'b1;
    idle(3);
    vecs++;
    if (pul0 !== 1'b0) begin
      errs++; $display("FAIL rst_pulse: got %b want 0", pul0);
    end
    vecs++;
    if (lck0 !== 1'b0) begin
      errs++; $display("FAIL rst_locked: got %b want 0", lck0);
    end
    vecs++;
    if (per0 !== 24'd0) begin
      errs++; $display("FAIL rst_period: got %0d want 0", per0);
    end
    vecs++;
    if (val0 !== 1'b0) begin
      errs++; $display("FAIL rst_valid: got %b want 0", val0);
    end
    sof_in[0] = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    vecs++;
    if (pul0 !== 1'b1) begin
      errs++; $display("FAIL rel_pulse: got %b want 1", pul0);
    end
    tick();
    vecs++;
    if (pul0 !== 1'b0) begin
      errs++; $display("FAIL rel_pulse2: got %b want 0", pul0);
    end
    sof_in[0] = 1'b0;
    en_in[0]  = 1'b0;
    tick();
    en_in[0] = 1'b1;
    idle(5);
  endtask

  task automatic test_lock();
    for (int i = 0; i < 5; i++) begin
      fire(0);
      vecs++;
      if (lck0 !== (i == 4)) begin
        errs++;
        $display("FAIL lock_e%0d: got %b want %b", i, lck0, i == 4);
      end
      vecs++;
      if (val0 !== (i >= 1)) begin
        errs++;
        $display("FAIL valid_e%0d: got %b want %b", i, val0, i >= 1);
      end
      if (i >= 1) begin
        vecs++;
        if (per0 !== 24'd100) begin
          errs++;
          $display("FAIL period_e%0d: got %0d want 100", i, per0);
        end
      end
      if (i == 0) begin
        tick();
        vecs++;
        if (pul0 !== 1'b0) begin
          errs++; $display("FAIL pulse_width: got %b want 0", pul0);
        end
        idle(98);
      end else if (i < 4) begin
        idle(99);
      end
    end
  endtask

  task automatic test_tracking();
    int p [7] = '{101, 100, 101, 101, 101, 101, 101};
    logic l [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      idle(p[i] - 1);
      fire(0);
      vecs++;
      if (lck0 !== l[i]) begin
        errs++;
        $display("FAIL track_lock%0d: got %b want %b", i, lck0, l[i]);
      end
      vecs++;
      if (per0 !== 24'(p[i])) begin
        errs++;
        $display("FAIL track_per%0d: got %0d want %0d", i, per0, p[i]);
      end
    end
  endtask

  task automatic test_enable();
    idle(50);
    en_in[0] = 1'b0;
    tick();
    vecs++;
    if (lck0 !== 1'b0) begin
      errs++; $display("FAIL en_locked: got %b want 0", lck0);
    end
    vecs++;
    if (val0 !== 1'b0) begin
      errs++; $display("FAIL en_valid: got %b want 0", val0);
    end
    en_in[0] = 1'b1;
    idle(10);
    for (int i = 0; i < 5; i++) begin
      fire(0);
      vecs++;
      if (lck0 !== (i == 4)) begin
        errs++;
        $display("FAIL relock_f%0d: got %b want %b", i, lck0, i == 4);
      end
      if (i == 0) begin
        vecs++;
        if (val0 !== 1'b0) begin
          errs++; $display("FAIL relock_valid: got %b want 0", val0);
        end
      end
      if (i < 4) idle(99);
    end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1;
    #1;
    vecs++;
    if (pul0 !== 1'b0) begin
      errs++; $display("FAIL mid_pulse: got %b want 0", pul0);
    end
    vecs++;
    if (lck0 !== 1'b0) begin
      errs++; $display("FAIL mid_locked: got %b want 0", lck0);
    end
    vecs++;
    if (per0 !== 24'd0) begin
      errs++; $display("FAIL mid_period: got %0d want 0", per0);
    end
    vecs++;
    if (val0 !== 1'b0) begin
      errs++; $display("FAIL mid_valid: got %b want 0", val0);
    end
    tick();
    rst = 1'b0;
    idle(3);
    fire(0);
    idle(99);
    fire(0);
    vecs++;
    if (lck0 !== 1'b0 || val0 !== 1'b1) begin
      errs++;
      $display("FAIL mid_reacq: locked=%b valid=%b want 0/1",
               lck0, val0);
    end
  endtask

  task automatic test_tolerance();
    int p [6] = '{100, 102, 98, 101, 97, 97};
    logic l [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    fire(1);
    for (int i = 0; i < 6; i++) begin
      idle(p[i] - 1);
      fire(1);
      vecs++;
      if (lck1 !== l[i]) begin
        errs++;
        $display("FAIL tol_lock%0d: got %b want %b", i, lck1, l[i]);
      end
      vecs++;
      if (per1 !== 24'(p[i])) begin
        errs++;
        $display("FAIL tol_per%0d: got %0d want %0d", i, per1, p[i]);
      end
    end
  endtask

  task automatic test_timeout();
    fire(2);
    for (int i = 0; i < 4; i++) begin
      idle(99);
      fire(2);
    end
    vecs++;
    if (lck2 !== 1'b1 || per2 !== 8'd100) begin
      errs++;
      $display("FAIL to_lock: locked=%b period=%0d want 1/100",
               lck2, per2);
    end
    idle(254);
    vecs++;
    if (lck2 !== 1'b1 || val2 !== 1'b1) begin
      errs++;
      $display("FAIL to_early: locked=%b valid=%b want 1/1",
               lck2, val2);
    end
    tick();
    vecs++;
    if (lck2 !== 1'b0 || val2 !== 1'b0) begin
      errs++;
      $display("FAIL to_drop: locked=%b valid=%b want 0/0",
               lck2, val2);
    end
    fire(2);
    vecs++;
    if (val2 !== 1'b0) begin
      errs++; $display("FAIL to_first: valid=%b want 0", val2);
    end
    idle(254);
    fire(2);
    vecs++;
    if (val2 !== 1'b0 || per2 !== 8'd100) begin
      errs++;
      $display("FAIL to_stale: valid=%b period=%0d want 0/100",
               val2, per2);
    end
    idle(99);
    fire(2);
    vecs++;
    if (val2 !== 1'b1 || per2 !== 8'd100 || lck2 !== 1'b0) begin
      errs++;
      $display("FAIL to_restart: valid=%b period=%0d locked=%b want 1/100/0",
               val2, per2, lck2);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_tracking();
    test_enable();
    test_rst_mid();
    test_tolerance();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, errs=%0d", errs);
    $fatal(1);
  end

endmodule
